// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: groups the ID-stage instruction fields with the
// hazard-resolution results returned by the scoreboard.
//   master (pipeline control): drives id_valid, id_src1, id_src2, id_two_src,
//     id_wb_en, id_mem_read, id_dest, branch_taken; reads stall, fwd_sel1,
//     fwd_sel2, busy_map, stall_cnt.
//   slave (hazard_scoreboard): the mirror image.
// Parameters must match those of the hazard_scoreboard instance it connects.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 2
) ();
    localparam int unsigned SW = $clog2(DEPTH + 1);

    logic                   id_valid;
    logic [REG_AW-1:0]      id_src1;
    logic [REG_AW-1:0]      id_src2;
    logic                   id_two_src;
    logic                   id_wb_en;
    logic                   id_mem_read;
    logic [REG_AW-1:0]      id_dest;
    logic                   branch_taken;
    logic                   stall;
    logic [SW-1:0]          fwd_sel1;
    logic [SW-1:0]          fwd_sel2;
    logic [2**REG_AW-1:0]   busy_map;
    logic [15:0]            stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_read, id_dest,
               branch_taken,
        input  stall, fwd_sel1, fwd_sel2, busy_map, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_read, id_dest,
               branch_taken,
        output stall, fwd_sel1, fwd_sel2, busy_map, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard. Tracks the destinations of the DEPTH instructions
// in flight after ID (entry 1 = EXE, entry 2 = MEM, ...) and, for the
// instruction in ID, decides whether it must stall and where its operands
// come from.
//   FWD_EN = 1: forwarding; only a load-use on entry 1 stalls, operands are
//               forwarded from the youngest matching entry.
//   FWD_EN = 0: stall-only; any pending writer of a source stalls.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - hazard_scoreboard_if slave modport (ID fields in, stall/forward
//          selects/busy map/saturating stall counter out)
module hazard_scoreboard #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned DEPTH  = 2,
    parameter bit          FWD_EN = 1'b1
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_read;
        logic [REG_AW-1:0] dest;
    } entry_t;

    entry_t               ent_q [1:DEPTH];
    logic [15:0]          stall_cnt_q;

    logic [DEPTH:1]       hit1;
    logic [DEPTH:1]       hit2;
    logic [SW-1:0]        sel1;
    logic [SW-1:0]        sel2;
    logic [2**REG_AW-1:0] busy;
    logic                 hazard;
    logic                 stall_w;
    logic                 issue;

    // Only valid writers count as producers; bubbles and non-writers are inert.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        busy = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (ent_q[k].valid && ent_q[k].wb_en) begin
                busy[ent_q[k].dest] = 1'b1;
                hit1[k] = (ent_q[k].dest == bus.id_src1);
                hit2[k] = bus.id_two_src && (ent_q[k].dest == bus.id_src2);
            end
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the select.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (hit1[k]) sel1 = SW'(k);
            if (hit2[k]) sel2 = SW'(k);
        end
    end

    always_comb begin
        if (FWD_EN) begin
            // A load's data is not ready in EXE; everything else forwards.
            hazard = ent_q[1].mem_read && (hit1[1] || hit2[1]);
        end else begin
            hazard = |{hit1, hit2};
        end
        // A flush squashes the ID instruction, so it never waits.
        stall_w = bus.id_valid && hazard && !bus.branch_taken;
        issue   = bus.id_valid && !stall_w && !bus.branch_taken;
    end

    assign bus.stall     = stall_w;
    assign bus.fwd_sel1  = FWD_EN ? sel1 : '0;
    assign bus.fwd_sel2  = FWD_EN ? sel2 : '0;
    assign bus.busy_map  = busy;
    assign bus.stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            // Non-issue cycles insert a bubble; payload bits are don't-care then.
            ent_q[1] <= '{valid:    issue,
                          wb_en:    bus.id_wb_en,
                          mem_read: bus.id_mem_read,
                          dest:     bus.id_dest};
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
            if (stall_w && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: a forwarding instance (bf/dut_f) and a stall-only
// instance (bs/dut_s), both DEPTH=2, REG_AW=4, fed identical ID stimulus.
module tb_hazard_scoreboard;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_two_src, id_wb_en, id_mem_read, branch_taken;
    logic [3:0] id_src1, id_src2, id_dest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(4), .DEPTH(DEPTH)) bf ();
    hazard_scoreboard_if #(.REG_AW(4), .DEPTH(DEPTH)) bs ();

    assign bf.id_valid = id_valid;     assign bs.id_valid = id_valid;
    assign bf.id_src1 = id_src1;       assign bs.id_src1 = id_src1;
    assign bf.id_src2 = id_src2;       assign bs.id_src2 = id_src2;
    assign bf.id_two_src = id_two_src; assign bs.id_two_src = id_two_src;
    assign bf.id_wb_en = id_wb_en;     assign bs.id_wb_en = id_wb_en;
    assign bf.id_mem_read = id_mem_read; assign bs.id_mem_read = id_mem_read;
    assign bf.id_dest = id_dest;       assign bs.id_dest = id_dest;
    assign bf.branch_taken = branch_taken; assign bs.branch_taken = branch_taken;

    hazard_scoreboard #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(1'b1)) dut_f (
        .clk(clk), .rst(rst), .bus(bf));
    hazard_scoreboard #(.REG_AW(4), .DEPTH(DEPTH), .FWD_EN(1'b0)) dut_s (
        .clk(clk), .rst(rst), .bus(bs));

    // Reference model, index m: 0 = forwarding, 1 = stall-only.
    // Slot k holds the instruction that left ID k cycles ago (1 = youngest).
    bit         mv [2][DEPTH+1];
    bit         mw [2][DEPTH+1];
    bit         mm [2][DEPTH+1];
    int         md [2][DEPTH+1];
    bit         exp_stall [2];
    int         exp_sel1 [2];
    int         exp_sel2 [2];
    logic [15:0] exp_busy [2];
    int         exp_cnt [2];

    function automatic void model_eval();
        for (int m = 0; m < 2; m++) begin
            int k1;
            int k2;
            bit haz;
            k1 = 0;
            k2 = 0;
            exp_busy[m] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (mv[m][k] && mw[m][k]) begin
                    exp_busy[m][md[m][k]] = 1'b1;
                    if (md[m][k] == int'(id_src1)) k1 = k;
                    if (id_two_src && md[m][k] == int'(id_src2)) k2 = k;
                end
            end
            if (m == 0) haz = mm[m][1] && (k1 == 1 || k2 == 1);
            else        haz = (k1 != 0) || (k2 != 0);
            exp_stall[m] = id_valid && !branch_taken && haz;
            exp_sel1[m]  = (m == 0) ? k1 : 0;
            exp_sel2[m]  = (m == 0) ? k2 : 0;
        end
    endfunction

    function automatic void model_commit();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int k = 1; k <= DEPTH; k++) mv[m][k] = 1'b0;
                exp_cnt[m] = 0;
            end else begin
                for (int k = DEPTH; k >= 2; k--) begin
                    mv[m][k] = mv[m][k-1]; mw[m][k] = mw[m][k-1];
                    mm[m][k] = mm[m][k-1]; md[m][k] = md[m][k-1];
                end
                mv[m][1] = id_valid && !exp_stall[m] && !branch_taken;
                mw[m][1] = id_wb_en; mm[m][1] = id_mem_read; md[m][1] = int'(id_dest);
                if (exp_stall[m] && exp_cnt[m] < 65535) exp_cnt[m]++;
            end
        end
    endfunction

    task automatic drive(input bit v, input int s1, input int s2, input bit two,
                         input bit wb, input bit mr, input int d, input bit br);
        id_valid = v; id_src1 = 4'(s1); id_src2 = 4'(s2); id_two_src = two;
        id_wb_en = wb; id_mem_read = mr; id_dest = 4'(d); branch_taken = br;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    // Advance one clock; returns on the following falling edge.
    task automatic cycle();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 2, 1, 1, 1, 3, 0);
        cycle();
        cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bf.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_f got %0b want 0", bf.stall); end
        checks++; if (bs.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_s got %0b want 0", bs.stall); end
        checks++; if (bf.fwd_sel1 !== 2'd0 || bf.fwd_sel2 !== 2'd0) begin errors++; $display("FAIL reset_sel_f got %0d/%0d want 0/0", bf.fwd_sel1, bf.fwd_sel2); end
        checks++; if (bf.busy_map !== 16'h0) begin errors++; $display("FAIL reset_busy_f got %h want 0", bf.busy_map); end
        checks++; if (bs.busy_map !== 16'h0) begin errors++; $display("FAIL reset_busy_s got %h want 0", bs.busy_map); end
        checks++; if (bf.stall_cnt !== 16'h0 || bs.stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bf.stall_cnt, bs.stall_cnt); end
    endtask

    // Forwarding distance in fwd mode; 2-cycle RAW stall in stall-only mode.
    task automatic test_forward_and_stall();
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 3, 0);
        settle();
        checks++; if (bf.stall !== 1'b0) begin errors++; $display("FAIL fwd_issue_stall got %0b want 0", bf.stall); end
        cycle();
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bf.stall !== 1'b0 || bf.fwd_sel1 !== 2'd1) begin errors++; $display("FAIL fwd_exe got stall %0b sel1 %0d want 0/1", bf.stall, bf.fwd_sel1); end
        checks++; if (bs.stall !== 1'b1 || bs.fwd_sel1 !== 2'd0) begin errors++; $display("FAIL raw_stall1 got stall %0b sel1 %0d want 1/0", bs.stall, bs.fwd_sel1); end
        cycle();
        settle();
        checks++; if (bf.fwd_sel1 !== 2'd2) begin errors++; $display("FAIL fwd_mem got %0d want 2", bf.fwd_sel1); end
        checks++; if (bs.stall !== 1'b1) begin errors++; $display("FAIL raw_stall2 got %0b want 1", bs.stall); end
        cycle();
        settle();
        checks++; if (bs.stall !== 1'b0 || bs.stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_issue got stall %0b cnt %0d want 0/2", bs.stall, bs.stall_cnt); end
        checks++; if (bf.fwd_sel1 !== 2'd0 || bf.stall_cnt !== 16'd0) begin errors++; $display("FAIL fwd_retired got sel1 %0d cnt %0d want 0/0", bf.fwd_sel1, bf.stall_cnt); end
        cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 5, 0);
        cycle();
        drive(1, 0, 5, 1, 0, 0, 0, 0);
        settle();
        checks++; if (bf.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %0b want 1", bf.stall); end
        cycle();
        settle();
        checks++; if (bf.stall !== 1'b0 || bf.fwd_sel2 !== 2'd2) begin errors++; $display("FAIL load_use_fwd got stall %0b sel2 %0d want 0/2", bf.stall, bf.fwd_sel2); end
        checks++; if (bf.stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", bf.stall_cnt); end
        checks++; if (bs.stall !== exp_stall[1]) begin errors++; $display("FAIL load_use_s got %0b want %0b", bs.stall, exp_stall[1]); end
        cycle();
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 7, 0);
        cycle();
        cycle();
        drive(1, 7, 7, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bf.fwd_sel1 !== 2'd1) begin errors++; $display("FAIL youngest_sel1 got %0d want 1", bf.fwd_sel1); end
        checks++; if (bf.fwd_sel2 !== 2'd0 || bf.stall !== 1'b0) begin errors++; $display("FAIL one_src_sel2 got sel2 %0d stall %0b want 0/0", bf.fwd_sel2, bf.stall); end
        checks++; if (bf.busy_map !== 16'h0080) begin errors++; $display("FAIL youngest_busy got %h want 0080", bf.busy_map); end
        cycle();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 5, 0);
        cycle();
        drive(1, 5, 0, 0, 1, 0, 9, 1);
        settle();
        checks++; if (bf.stall !== 1'b0 || bs.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b/%0b want 0/0", bf.stall, bs.stall); end
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bf.busy_map !== 16'h0020) begin errors++; $display("FAIL flush_busy_f got %h want 0020", bf.busy_map); end
        checks++; if (bs.busy_map !== 16'h0020) begin errors++; $display("FAIL flush_busy_s got %h want 0020", bs.busy_map); end
        cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 2, 0);
        cycle();
        drive(1, 2, 0, 0, 1, 0, 6, 0);
        cycle();
        cycle();
        drive(1, 0, 0, 0, 1, 0, 8, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bf.busy_map !== 16'h0140 || bf.stall_cnt !== 16'd1) begin errors++; $display("FAIL midflight_pre got busy %h cnt %0d want 0140/1", bf.busy_map, bf.stall_cnt); end
        rst = 1'b1;
        drive(1, 0, 0, 0, 1, 0, 11, 0);
        cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (bf.busy_map !== 16'h0 || bf.stall_cnt !== 16'd0) begin errors++; $display("FAIL midflight_rst_f got busy %h cnt %0d want 0/0", bf.busy_map, bf.stall_cnt); end
        checks++; if (bs.busy_map !== 16'h0 || bs.stall_cnt !== 16'd0) begin errors++; $display("FAIL midflight_rst_s got busy %h cnt %0d want 0/0", bs.busy_map, bs.stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut_s.stall_cnt_q = 16'hFFFD;
        #1;
        release dut_s.stall_cnt_q;
        exp_cnt[1] = 65533;
        drive(1, 1, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            settle();
            checks++; if (int'(bs.stall_cnt) !== exp_cnt[1]) begin errors++; $display("FAIL sat_cnt cycle %0d got %0d want %0d", i, bs.stall_cnt, exp_cnt[1]); end
            cycle();
        end
        settle();
        checks++; if (bs.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want FFFF", bs.stall_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 9) == 0));
            settle();
            checks++; if (bf.stall !== exp_stall[0] || bs.stall !== exp_stall[1]) begin errors++; $display("FAIL rnd_stall %0d got %0b/%0b want %0b/%0b", i, bf.stall, bs.stall, exp_stall[0], exp_stall[1]); end
            checks++; if (int'(bf.fwd_sel1) !== exp_sel1[0] || int'(bf.fwd_sel2) !== exp_sel2[0]) begin errors++; $display("FAIL rnd_sel_f %0d got %0d/%0d want %0d/%0d", i, bf.fwd_sel1, bf.fwd_sel2, exp_sel1[0], exp_sel2[0]); end
            checks++; if (bs.fwd_sel1 !== 2'd0 || bs.fwd_sel2 !== 2'd0) begin errors++; $display("FAIL rnd_sel_s %0d got %0d/%0d want 0/0", i, bs.fwd_sel1, bs.fwd_sel2); end
            checks++; if (bf.busy_map !== exp_busy[0] || bs.busy_map !== exp_busy[1]) begin errors++; $display("FAIL rnd_busy %0d got %h/%h want %h/%h", i, bf.busy_map, bs.busy_map, exp_busy[0], exp_busy[1]); end
            checks++; if (int'(bf.stall_cnt) !== exp_cnt[0] || int'(bs.stall_cnt) !== exp_cnt[1]) begin errors++; $display("FAIL rnd_cnt %0d got %0d/%0d want %0d/%0d", i, bf.stall_cnt, bs.stall_cnt, exp_cnt[0], exp_cnt[1]); end
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            exp_cnt[m] = 0;
            for (int k = 0; k <= DEPTH; k++) begin
                mv[m][k] = 1'b0; mw[m][k] = 1'b0; mm[m][k] = 1'b0; md[m][k] = 0;
            end
        end
        test_reset();
        test_forward_and_stall();
        test_load_use();
        test_youngest();
        test_flush();
        test_reset_midflight();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 4: register-index width; the register file holds 2^REG_AW registers.
REQ-002 SHALL have parameter DEPTH, default 2, legal range 1-8: tracked stages after ID (entry 1 = EXE, entry 2 = MEM, ...).
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forwarding mode; 0 = stall-only mode.
REQ-004 SHALL define SW = clog2(DEPTH+1) as the width of the forwarding selects.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port id_valid, input, 1: the ID stage holds a valid instruction.
REQ-008 SHALL have ports id_src1 and id_src2, input, REG_AW: source register indices of the ID instruction.
REQ-009 SHALL have port id_two_src, input, 1: id_src2 is a real operand.
REQ-010 SHALL have port id_wb_en, input, 1: the ID instruction writes id_dest.
REQ-011 SHALL have port id_mem_read, input, 1: the ID instruction is a load.
REQ-012 SHALL have port id_dest, input, REG_AW: destination register of the ID instruction.
REQ-013 SHALL have port branch_taken, input, 1: flush; the ID instruction is squashed.
REQ-014 SHALL have port stall, output, 1: freeze IF/ID and insert a bubble.
REQ-015 SHALL have ports fwd_sel1 and fwd_sel2, output, SW: 0 = register file; k = forward from entry k.
REQ-016 SHALL have port busy_map, output, 2^REG_AW: bit r set when any valid entry has wb_en and dest r.
REQ-017 SHALL have port stall_cnt, output, 16: number of stall cycles since reset, saturating.

Function
REQ-018 SHALL hold a shift pipeline of DEPTH entries, each entry = {valid, wb_en, mem_read, dest}.
REQ-019 SHALL issue when id_valid & ~stall & ~branch_taken.
REQ-020 SHALL, each clock, load entry 1 with the ID fields on issue and with a bubble (valid=0) otherwise, and shift entry k into entry k+1; the oldest entry retires.
REQ-021 SHALL define match(s,k) = entry k valid & wb_en & dest==s; src2 is checked only when id_two_src=1.
REQ-022 SHALL, when FWD_EN=0, drive stall = id_valid & (any k: match(src1,k) | match(src2,k)), with fwd_sel1 = fwd_sel2 = 0.
REQ-023 SHALL, when FWD_EN=1, drive stall = id_valid & entry1.mem_read & (match(src1,1) | match(src2,1)), i.e. load-use only.
REQ-024 SHALL, when FWD_EN=1, drive fwd_selN = the smallest k with match(srcN,k), so the youngest producer wins; 0 if none.
REQ-025 SHALL drive stall, fwd_sel and busy_map combinationally from the current inputs and entries, with zero latency.
REQ-026 SHALL force stall=0 when branch_taken=1, since the flush overrides the stall; the squashed instruction is not issued.
REQ-027 SHALL ensure a stalled instruction issues in the first cycle its hazard clears; with FWD_EN=1 a load-use stall lasts exactly 1 cycle.
REQ-028 SHALL increment stall_cnt on each cycle with stall=1 and hold it at 16'hFFFF once reached, with no wrap.
REQ-029 SHALL never let entries with wb_en=0 or valid=0 cause a match, a forward or a busy_map bit.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear all entries to invalid and stall_cnt to 0, giving stall=0, fwd_sel=0 and busy_map=0 from the next cycle.
REQ-031 SHALL give rst priority over issue and shift, so an in-flight scoreboard is discarded mid-operation.

Verification
REQ-032 SHALL verify, with FWD_EN=1, DEPTH=2: issue ADD dest=3; next cycle ID src1=3 -> stall=0, fwd_sel1=1; following cycle src1=3 -> fwd_sel1=2.
REQ-033 SHALL verify, with FWD_EN=1: issue LDR dest=5 (mem_read=1); next cycle ID src2=5, two_src=1 -> stall=1 for 1 cycle, then fwd_sel2=2, stall=0, stall_cnt=1.
REQ-034 SHALL verify, with FWD_EN=0, DEPTH=2: issue wb to r4; dependent src1=4 -> stall=1 for 2 cycles, issue on the 3rd, stall_cnt=2.
REQ-035 SHALL verify: two consecutive writers to r7, then reader of r7 -> fwd_sel1=1 (youngest); src2=7 with two_src=0 -> fwd_sel2=0.
REQ-036 SHALL verify: branch_taken=1 during a load-use hazard -> stall=0, entry 1 bubble next cycle, busy_map excludes the squashed dest.
REQ-037 SHALL verify: rst asserted with 2 valid entries -> busy_map=0, stall_cnt=0 next cycle; stall_cnt forced near 16'hFFFF saturates.
